instr_mem_responder: RTL and testbench
======================================

INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning the number of 32-bit words in the memory array (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of word 0 (MEM_WORDS*4 aligned).
REQ-003 SHALL have parameter LATENCY, default 2, legal range 1..4, meaning the cycles from a grant to its rvalid.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2, legal range 1..LATENCY, meaning the maximum number of granted requests awaiting response.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rstn  input  1  reset, synchronous and active-low.
REQ-007 instr_req_i  input  1  request from the fetch initiator.
REQ-008 instr_gnt_o  output  1  request accepted this cycle.
REQ-009 instr_addr_i  input  32  byte address of the requested instruction word.
REQ-010 instr_rdata_o  output  32  returned instruction word.
REQ-011 instr_rvalid_o  output  1  instr_rdata_o/instr_err_o valid this cycle.
REQ-012 instr_err_o  output  1  the response is for an out-of-range address.
REQ-013 wait_i  input  1  wait-state injection; when high, no grant is given.
REQ-014 load_we_i  input  1  backdoor word write enable (boot loader/bench).
REQ-015 load_addr_i  input  32  backdoor byte address.
REQ-016 load_wdata_i  input  32  backdoor write data.
REQ-017 outstanding_o  output  3  count of granted-but-unanswered requests.

Function
REQ-018 instr_gnt_o SHALL be combinational: instr_req_i & ~wait_i & (outstanding < MAX_OUTSTANDING | a response retires this cycle) & rstn.
REQ-019 A handshake SHALL occur on every cycle where instr_req_i and instr_gnt_o are both high; back-to-back handshakes on consecutive cycles SHALL be supported.
REQ-020 For each handshake in cycle N, exactly one response (instr_rvalid_o=1 for one cycle) SHALL appear in cycle N+LATENCY.
REQ-021 Responses SHALL be returned in grant order.
REQ-022 The address SHALL be in range when BASE_ADDR <= instr_addr_i < BASE_ADDR+4*MEM_WORDS.
REQ-023 For an in-range address, the word index SHALL be (instr_addr_i-BASE_ADDR)[..:2], and instr_addr_i[1:0] SHALL be ignored (a halfword-aligned fetch returns its containing word).
REQ-024 The memory word SHALL be sampled in the grant cycle and carried through a LATENCY-deep pipeline of {valid, err, data}.
REQ-025 For an out-of-range address, the response SHALL have instr_err_o=1 and instr_rdata_o=0; in-range responses SHALL have instr_err_o=0.
REQ-026 When instr_rvalid_o=0, instr_rdata_o and instr_err_o SHALL be 0.
REQ-027 outstanding_o SHALL increment on a grant, decrement on a response, and stay unchanged when both occur in the same cycle; it SHALL never exceed MAX_OUTSTANDING.
REQ-028 A backdoor write SHALL update the word at the in-range index at the clock edge; out-of-range backdoor writes SHALL be dropped.
REQ-029 A backdoor write and a grant to the same word in the same cycle SHALL return the old data (read-before-write).
REQ-030 Changes to instr_addr_i or instr_req_i without a grant SHALL have no effect on state.
REQ-031 Memory contents SHALL persist across reset and are undefined until written.

Reset
REQ-032 When rstn=0 at a clock edge, all pipeline valids, instr_rvalid_o, instr_err_o, instr_rdata_o and outstanding_o SHALL become 0.
REQ-033 instr_gnt_o SHALL be 0 while rstn=0.
REQ-034 Requests in flight at reset SHALL be discarded and never answered.
REQ-035 The first grant SHALL be possible in the first cycle with rstn=1.

Verification
REQ-036 LATENCY=2: preload word0=0x00000013, word1=0x00A00093; requests at 0x0 then 0x4 on consecutive cycles -> gnt=1 both; rvalid in cycles N+2 and N+3 with rdata 0x00000013 then 0x00A00093, err=0.
REQ-037 A request at 0x6 -> returns word1 (0x00A00093); a request at BASE_ADDR+4*MEM_WORDS -> rvalid with err=1, rdata=0.
REQ-038 MAX_OUTSTANDING=1, LATENCY=2, continuous req -> gnt pattern 1,0,1,0…; outstanding_o never exceeds 1; one rvalid per grant.
REQ-039 wait_i=1 for 3 cycles with req held -> no gnt and no rvalid from those cycles; first gnt in the cycle wait_i drops.
REQ-040 Two grants issued, then rstn=0 for one cycle before their responses -> no rvalid afterward; outstanding_o=0; memory contents intact on re-read.
REQ-041 A backdoor write of 0xDEADBEEF to word 3 in the same cycle as a grant to 0xC -> the response returns the old value; the next read of 0xC returns 0xDEADBEEF.

Source files
------------

// File: rtl/instr_mem_responder.sv
// ---------------------------------------------------------------------------
// instr_mem_responder
//   Instruction-fetch memory slave with a req/gnt/rvalid handshake, a fixed
//   response latency, a bounded number of outstanding requests and a
//   backdoor write port used to preload code.
//
// Parameters
//   MEM_WORDS        number of 32-bit words in the array (power of two)
//   BASE_ADDR        byte address of word 0 (MEM_WORDS*4 aligned)
//   LATENCY          cycles from grant to rvalid (1..4)
//   MAX_OUTSTANDING  granted-but-unanswered requests allowed (1..LATENCY)
//
// Ports
//   clk             clock, rising edge
//   rstn            synchronous active-low reset
//   instr_req_i     fetch request
//   instr_gnt_o     request accepted this cycle (combinational)
//   instr_addr_i    fetch byte address
//   instr_rdata_o   returned word (0 when no response)
//   instr_rvalid_o  response valid
//   instr_err_o     response is for an out-of-range address
//   wait_i          wait-state injection, blocks grants
//   load_we_i       backdoor write enable
//   load_addr_i     backdoor byte address
//   load_wdata_i    backdoor write data
//   outstanding_o   granted-but-unanswered request count
// ---------------------------------------------------------------------------
module instr_mem_responder #(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_rvalid_o,
  output logic        instr_err_o,
  input  logic        wait_i,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_wdata_i,
  output logic [2:0]  outstanding_o
);

  localparam int unsigned IW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  // 33 bits so that BASE_ADDR + 4*MEM_WORDS == 2^32 is still representable.
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  logic [31:0] mem [MEM_WORDS];

  logic        pipe_valid [LATENCY];
  logic        pipe_err   [LATENCY];
  logic [31:0] pipe_data  [LATENCY];
  logic [2:0]  outstanding;

  logic [31:0]   rd_off;
  logic [31:0]   ld_off;
  logic          rd_in_range;
  logic          ld_in_range;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] ld_idx;
  logic [31:0]   rd_word;
  logic          gnt;
  logic          retire;

  always_comb begin
    rd_off      = instr_addr_i - BASE_ADDR;
    ld_off      = load_addr_i - BASE_ADDR;
    rd_in_range = (instr_addr_i >= BASE_ADDR) && ({1'b0, rd_off} < MEM_BYTES);
    ld_in_range = (load_addr_i >= BASE_ADDR) && ({1'b0, ld_off} < MEM_BYTES);
    // Byte-offset bits [1:0] are dropped: sub-word fetches return the whole word.
    rd_idx      = rd_off[IW+1:2];
    ld_idx      = ld_off[IW+1:2];
    rd_word     = rd_in_range ? mem[rd_idx] : '0;
    retire      = pipe_valid[LATENCY-1];
    // A retiring response frees a slot in the same cycle, so a full window
    // can still accept a new request.
    gnt         = instr_req_i & ~wait_i & rstn &
                  ((outstanding < 3'(MAX_OUTSTANDING)) | retire);
  end

  // Array contents are deliberately not reset. The read above samples the
  // pre-edge value, so a same-cycle backdoor write is seen only by later reads.
  always_ff @(posedge clk) begin
    if (load_we_i && ld_in_range) begin
      mem[ld_idx] <= load_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_err[i]   <= 1'b0;
        pipe_data[i]  <= '0;
      end
      outstanding <= '0;
    end else begin
      // Non-granted slots carry zeros so idle outputs read as 0.
      pipe_valid[0] <= gnt;
      pipe_err[0]   <= gnt & ~rd_in_range;
      pipe_data[0]  <= gnt ? rd_word : '0;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
      case ({gnt, retire})
        2'b10:   outstanding <= outstanding + 3'd1;
        2'b01:   outstanding <= outstanding - 3'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign instr_gnt_o    = gnt;
  assign instr_rvalid_o = pipe_valid[LATENCY-1];
  assign instr_err_o    = pipe_err[LATENCY-1];
  assign instr_rdata_o  = pipe_data[LATENCY-1];
  assign outstanding_o  = outstanding;

endmodule

// File: tb/tb_instr_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_responder
//   Self-checking bench. u_dut (MAX_OUTSTANDING=2) is tracked by a response
//   scoreboard; u_dut1 (MAX_OUTSTANDING=1) shares all inputs and is checked
//   for its alternating grant pattern.
// ---------------------------------------------------------------------------
module tb_instr_mem_responder;

  localparam int unsigned MW   = 256;
  localparam int unsigned LAT  = 2;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] END_ADDR = BASE + 32'(4 * MW);

  logic        clk = 1'b0;
  logic        rstn;
  logic        req;
  logic        wait_in;
  logic [31:0] addr;
  logic        load_we;
  logic [31:0] load_addr;
  logic [31:0] load_wdata;

  logic        gnt, rvalid, err;
  logic [31:0] rdata;
  logic [2:0]  outstanding;
  logic        gnt1, rvalid1, err1;
  logic [31:0] rdata1;
  logic [2:0]  outstanding1;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mon_en   = 1'b0;
  int unsigned cyc      = 0;

  typedef struct {
    int unsigned due;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e_mon;
  logic [31:0] model [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  instr_mem_responder #(
    .MEM_WORDS(MW), .BASE_ADDR(BASE), .LATENCY(LAT), .MAX_OUTSTANDING(2)
  ) u_dut (
    .clk(clk), .rstn(rstn), .instr_req_i(req), .instr_gnt_o(gnt),
    .instr_addr_i(addr), .instr_rdata_o(rdata), .instr_rvalid_o(rvalid),
    .instr_err_o(err), .wait_i(wait_in), .load_we_i(load_we),
    .load_addr_i(load_addr), .load_wdata_i(load_wdata),
    .outstanding_o(outstanding)
  );

  instr_mem_responder #(
    .MEM_WORDS(MW), .BASE_ADDR(BASE), .LATENCY(LAT), .MAX_OUTSTANDING(1)
  ) u_dut1 (
    .clk(clk), .rstn(rstn), .instr_req_i(req), .instr_gnt_o(gnt1),
    .instr_addr_i(addr), .instr_rdata_o(rdata1), .instr_rvalid_o(rvalid1),
    .instr_err_o(err1), .wait_i(wait_in), .load_we_i(load_we),
    .load_addr_i(load_addr), .load_wdata_i(load_wdata),
    .outstanding_o(outstanding1)
  );

  function automatic bit in_rng(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (off >= 0) && (off < longint'(4 * MW));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // Scoreboard: expectations are pushed on every handshake and popped when
  // u_dut answers; the model is updated after the read so a same-cycle
  // backdoor write yields the old word.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rvalid === 1'b1) begin
        n_checks++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_rvalid cyc=%0d: got rvalid=1 rdata=%h, required no response",
                   cyc, rdata);
        end else begin
          e_mon = sbq.pop_front();
          if (rdata !== e_mon.data || err !== e_mon.err || cyc !== e_mon.due) begin
            n_fail++;
            $display("FAIL sb_response: got cyc=%0d rdata=%h err=%b, required cyc=%0d rdata=%h err=%b",
                     cyc, rdata, err, e_mon.due, e_mon.data, e_mon.err);
          end
        end
      end else begin
        n_checks++;
        if (rvalid !== 1'b0 || rdata !== 32'h0 || err !== 1'b0) begin
          n_fail++;
          $display("FAIL sb_idle cyc=%0d: got rvalid=%b rdata=%h err=%b, required 0/0/0",
                   cyc, rvalid, rdata, err);
        end
        if (sbq.size() > 0 && sbq[0].due <= cyc) begin
          e_mon = sbq.pop_front();
          n_checks++;
          n_fail++;
          $display("FAIL sb_missing_rvalid cyc=%0d: got no response, required rdata=%h due cyc=%0d",
                   cyc, e_mon.data, e_mon.due);
        end
      end
      if (rstn === 1'b0) begin
        sbq.delete();
      end else if (req === 1'b1 && gnt === 1'b1) begin
        e_mon.due  = cyc + LAT;
        e_mon.err  = !in_rng(addr);
        e_mon.data = in_rng(addr) ? model[widx(addr)] : 32'h0;
        sbq.push_back(e_mon);
      end
      if (load_we === 1'b1 && in_rng(load_addr)) begin
        model[widx(load_addr)] = load_wdata;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req     = 1'b0;
    load_we = 1'b0;
    wait_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; req = 1'b1; addr = 32'h0; wait_in = 1'b0;
    load_we = 1'b0; load_addr = '0; load_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (gnt !== 1'b0 || gnt1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_gnt: got gnt=%b gnt1=%b, required 0", gnt, gnt1);
    end
    n_checks++;
    if (rvalid !== 1'b0 || rdata !== 32'h0 || err !== 1'b0 || outstanding !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: got rvalid=%b rdata=%h err=%b outstanding=%0d, required all 0",
               rvalid, rdata, err, outstanding);
    end
    // First cycle out of reset must already grant (out-of-range address, array still unwritten).
    tick();
    rstn = 1'b1;
    addr = END_ADDR;
    @(negedge clk);
    n_checks++;
    if (gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL first_grant: got gnt=%b, required 1", gnt);
    end
    tick();
    req = 1'b0;
  endtask

  task automatic test_preload();
    logic [31:0] words [4];
    words[0] = 32'h0000_0013; words[1] = 32'h00A0_0093;
    words[2] = 32'h0010_0113; words[3] = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      load_we    = 1'b1;
      load_addr  = BASE + 32'(4 * i);
      load_wdata = words[i];
      tick();
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    req = 1'b1; addr = BASE;
    @(negedge clk);
    n_checks++;
    if (gnt !== 1'b1) begin
      n_fail++; $display("FAIL b2b_gnt0: got %b, required 1", gnt);
    end
    tick(); addr = BASE + 32'h4;
    @(negedge clk);
    n_checks++;
    if (gnt !== 1'b1 || outstanding !== 3'd1) begin
      n_fail++; $display("FAIL b2b_gnt1: got gnt=%b outstanding=%0d, required 1/1", gnt, outstanding);
    end
    tick(); req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (outstanding !== 3'd2 || rvalid !== 1'b1 || rdata !== 32'h0000_0013 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_resp0: got out=%0d rvalid=%b rdata=%h err=%b, required 2/1/00000013/0",
               outstanding, rvalid, rdata, err);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h00A0_0093 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_resp1: got rvalid=%b rdata=%h err=%b, required 1/00a00093/0", rvalid, rdata, err);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (outstanding !== 3'd0) begin
      n_fail++; $display("FAIL b2b_drain: got outstanding=%0d, required 0", outstanding);
    end
    idle(2);
  endtask

  task automatic test_addr_range();
    logic [31:0] addrs [3];
    addrs[0] = BASE + 32'h6; addrs[1] = END_ADDR; addrs[2] = 32'hFFFF_FFFC;
    for (int i = 0; i < 3; i++) begin
      req = 1'b1; addr = addrs[i];
      @(negedge clk);
      n_checks++;
      if (gnt !== 1'b1) begin
        n_fail++; $display("FAIL range_gnt%0d: got %b, required 1", i, gnt);
      end
      tick();
    end
    idle(4);
  endtask

  task automatic test_wait();
    req = 1'b1; addr = BASE + 32'h8; wait_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (gnt !== 1'b0 || gnt1 !== 1'b0) begin
        n_fail++; $display("FAIL wait_gnt%0d: got gnt=%b gnt1=%b, required 0", i, gnt, gnt1);
      end
      tick();
    end
    wait_in = 1'b0;
    @(negedge clk);
    n_checks++;
    if (gnt !== 1'b1) begin
      n_fail++; $display("FAIL wait_release: got gnt=%b, required 1", gnt);
    end
    tick();
    idle(4);
  endtask

  task automatic test_max_outstanding();
    int g1 = 0;
    int r1 = 0;
    n_checks++;
    if (outstanding1 !== 3'd0) begin
      n_fail++; $display("FAIL max1_start: got outstanding1=%0d, required 0", outstanding1);
    end
    req = 1'b1; addr = BASE;
    for (int i = 0; i < 12; i++) begin
      if (i == 8) req = 1'b0;
      @(negedge clk);
      if (i < 8) begin
        n_checks++;
        if (gnt1 !== ((i % 2) == 0)) begin
          n_fail++; $display("FAIL max1_gnt%0d: got %b, required %b", i, gnt1, (i % 2) == 0);
        end
      end
      n_checks++;
      if (outstanding1 > 3'd1) begin
        n_fail++; $display("FAIL max1_outstanding%0d: got %0d, required <=1", i, outstanding1);
      end
      if (req === 1'b1 && gnt1 === 1'b1) g1++;
      if (rvalid1 === 1'b1) begin
        r1++;
        n_checks++;
        if (rdata1 !== 32'h0000_0013 || err1 !== 1'b0) begin
          n_fail++; $display("FAIL max1_rdata: got %h err=%b, required 00000013/0", rdata1, err1);
        end
      end
      tick();
    end
    n_checks++;
    if (g1 != 4 || r1 != g1) begin
      n_fail++; $display("FAIL max1_count: got grants=%0d rvalids=%0d, required 4/4", g1, r1);
    end
    idle(2);
  endtask

  task automatic test_reset_inflight();
    int late = 0;
    req = 1'b1; addr = BASE;
    @(negedge clk);
    tick(); addr = BASE + 32'h4;
    @(negedge clk);
    n_checks++;
    if (gnt !== 1'b1) begin
      n_fail++; $display("FAIL rst_inflight_gnt: got %b, required 1", gnt);
    end
    tick(); req = 1'b0; rstn = 1'b0;
    @(negedge clk);
    n_checks++;
    if (gnt !== 1'b0) begin
      n_fail++; $display("FAIL rst_inflight_gnt_low: got %b, required 0", gnt);
    end
    tick(); rstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outstanding !== 3'd0 || outstanding1 !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_inflight_outstanding: got %0d/%0d, required 0/0", outstanding, outstanding1);
    end
    for (int i = 0; i < 4; i++) begin
      if (rvalid === 1'b1 || rvalid1 === 1'b1) late++;
      tick();
      @(negedge clk);
    end
    n_checks++;
    if (late != 0) begin
      n_fail++; $display("FAIL rst_inflight_rvalid: got %0d late responses, required 0", late);
    end
    tick();
    req = 1'b1; addr = BASE;
    tick(); addr = BASE + 32'h4;
    tick();
    idle(4);
  endtask

  task automatic test_rbw();
    req = 1'b1; addr = BASE + 32'hC;
    load_we = 1'b1; load_addr = BASE + 32'hC; load_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++;
    if (gnt !== 1'b1) begin
      n_fail++; $display("FAIL rbw_gnt: got %b, required 1", gnt);
    end
    tick(); load_we = 1'b0;
    tick(); req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h1234_5678) begin
      n_fail++; $display("FAIL rbw_old: got rvalid=%b rdata=%h, required 1/12345678", rvalid, rdata);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL rbw_new: got rvalid=%b rdata=%h, required 1/deadbeef", rvalid, rdata);
    end
    // An out-of-range backdoor write must not alias onto word 0.
    tick();
    load_we = 1'b1; load_addr = END_ADDR; load_wdata = 32'hBAD0_BAD0;
    tick(); load_we = 1'b0; req = 1'b1; addr = BASE;
    tick();
    idle(4);
  endtask

  initial begin
    test_reset();
    test_preload();
    test_back_to_back();
    test_addr_range();
    test_wait();
    test_max_outstanding();
    test_reset_inflight();
    test_rbw();
    for (int i = 0; i < 20 && sbq.size() > 0; i++) tick();
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d pending responses, required 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
